// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
interface muldiv_unit_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] z;

    modport master (
        output in_valid, op, x, y, kill, out_ready,
        input  in_ready, out_valid, z
    );

    modport slave (
        input  in_valid, op, x, y, kill, out_ready,
        output in_ready, out_valid, z
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiplier and restoring
// divider on operand magnitudes, one bit per cycle, with flush and result hold.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   z_q;

    logic [2:0]        op_q;
    logic              w_q, neg_q, rneg_q;
    logic [2*XLEN-1:0] a, acc;
    logic [XLEN-1:0]   b;

    logic              accept, w_in, is_div, sx, sy, dz, ovf, special, last;
    logic [XLEN-1:0]   xs, ys, xm, ym, min_val, spec_raw, spec_res;
    logic [2*XLEN-1:0] acc_nx, prod;
    logic [XLEN:0]     sh, diff;
    logic [XLEN-1:0]   rem_nx, quo_nx, q_fix, r_fix, res_raw, res;
    logic [CW-1:0]     n_last;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
        return (s && v[XLEN-1]) ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] v, input logic w);
        return w ? sext32(v[31:0]) : v;
    endfunction

    always_comb begin
        w_in   = (XLEN == 64) && bus.op[3];
        is_div = bus.op[2];
        // Every word multiply is MULW, which only needs the low product word.
        sx     = is_div ? !bus.op[0] : (!w_in && (bus.op[1:0] == 2'd1 || bus.op[1:0] == 2'd2));
        sy     = is_div ? !bus.op[0] : (!w_in && bus.op[1:0] == 2'd1);
        xs     = bus.x;
        ys     = bus.y;
        if (w_in) begin
            xs = sx ? sext32(bus.x[31:0]) : XLEN'(bus.x[31:0]);
            ys = sy ? sext32(bus.y[31:0]) : XLEN'(bus.y[31:0]);
        end
        xm      = mag(xs, sx);
        ym      = mag(ys, sy);
        min_val = w_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        dz      = (ys == '0);
        ovf     = sx && (xs == min_val) && (&ys);
        special = is_div && (dz || ovf);
        if (dz) spec_raw = bus.op[1] ? xs : '1;
        else    spec_raw = bus.op[1] ? '0 : xs;
        spec_res = fmt(spec_raw, w_in);
        accept   = bus.in_valid && (state == IDLE) && !bus.kill;
    end

    // One multiply step (add then double) or one restoring divide step.
    always_comb begin
        acc_nx = acc + (b[0] ? a : '0);
        sh     = {acc[XLEN-1:0], b[XLEN-1]};
        diff   = sh - {1'b0, a[XLEN-1:0]};
        rem_nx = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
        quo_nx = {b[XLEN-2:0], !diff[XLEN]};
        prod   = neg_q ? -acc_nx : acc_nx;
        q_fix  = neg_q ? -quo_nx : quo_nx;
        r_fix  = rneg_q ? -rem_nx : rem_nx;
        if (op_q[2])                          res_raw = op_q[1] ? r_fix : q_fix;
        else if (op_q[1:0] == 2'd0 || w_q)    res_raw = prod[XLEN-1:0];
        else                                  res_raw = prod[2*XLEN-1:XLEN];
        res    = fmt(res_raw, w_q);
        n_last = w_q ? CW'(31) : CW'(XLEN - 1);
        last   = (state == CALC) && (cnt == n_last);
    end

    // Word divides shift the 32-bit dividend to the top so 32 steps consume it.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= bus.op[2:0];
            w_q    <= w_in;
            neg_q  <= (sx && xs[XLEN-1]) ^ (sy && ys[XLEN-1]);
            rneg_q <= sx && xs[XLEN-1];
            acc    <= '0;
            if (is_div) begin
                a <= {{XLEN{1'b0}}, ym};
                b <= w_in ? (xm << 32) : xm;
            end else begin
                a <= {{XLEN{1'b0}}, xm};
                b <= ym;
            end
        end else if (state == CALC) begin
            if (op_q[2]) begin
                acc <= {{XLEN{1'b0}}, rem_nx};
                b   <= quo_nx;
            end else begin
                acc <= acc_nx;
                a   <= a << 1;
                b   <= b >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            z_q   <= '0;
        end else begin
            state <= state_nx;
            if (accept)              cnt <= '0;
            else if (state == CALC)  cnt <= cnt + CW'(1);
            if (!bus.kill) begin
                if (accept && special) z_q <= spec_res;
                else if (last)         z_q <= res;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = special ? DONE : CALC;
            CALC:    if (last) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.kill) state_nx = IDLE;
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.z         = z_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand-written control sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_muldiv_unit;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if #(.XLEN(64)) bus ();

    muldiv_unit #(.XLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] z;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: full-precision arithmetic straight from the M-extension rules.
    function automatic logic [63:0] ref_z(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        logic signed [127:0] px, py, p;
        longint      sa, sb;
        int          sa32, sb32;
        logic [31:0] r32;
        logic [63:0] r;
        logic        ovf32, ovf64;
        sa = x; sb = y; sa32 = x[31:0]; sb32 = y[31:0];
        ovf32 = (x[31:0] == 32'h8000_0000) && (sb32 == -1);
        ovf64 = (x == 64'h8000_0000_0000_0000) && (sb == -1);
        r = '0;
        if (o[3]) begin
            r32 = x[31:0] * y[31:0];
            case (o[2:0])
                3'd4: if (sb32 == 0) r32 = '1; else if (ovf32) r32 = x[31:0]; else r32 = sa32 / sb32;
                3'd5: if (y[31:0] == 0) r32 = '1; else r32 = x[31:0] / y[31:0];
                3'd6: if (sb32 == 0) r32 = x[31:0]; else if (ovf32) r32 = '0; else r32 = sa32 % sb32;
                3'd7: if (y[31:0] == 0) r32 = x[31:0]; else r32 = x[31:0] % y[31:0];
                default: ;
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (o[2:0])
            3'd0: r = x * y;
            3'd1: begin px = {{64{x[63]}}, x}; py = {{64{y[63]}}, y}; p = px * py; r = p[127:64]; end
            3'd2: begin px = {{64{x[63]}}, x}; py = {64'd0, y};       p = px * py; r = p[127:64]; end
            3'd3: begin px = {64'd0, x};       py = {64'd0, y};       p = px * py; r = p[127:64]; end
            3'd4: if (y == 0) r = '1; else if (ovf64) r = x; else r = sa / sb;
            3'd5: if (y == 0) r = '1; else r = x / y;
            3'd6: if (y == 0) r = x; else if (ovf64) r = '0; else r = sa % sb;
            3'd7: if (y == 0) r = x; else r = x % y;
            default: ;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        logic zero, ovf;
        zero = o[3] ? (y[31:0] == 0) : (y == 0);
        ovf  = !o[0] && (o[3] ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
                              : (x == 64'h8000_0000_0000_0000 && y == '1));
        if (o[2] && (zero || ovf)) return 0;
        return o[3] ? 32 : 64;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 20));
            4:       return {$urandom(), 32'h8000_0000};
            5:       return {$urandom(), 32'hFFFF_FFFF};
            6:       return {32'h0, $urandom()};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        int t = 0;
        while (!bus.in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        bus.op = o; bus.x = a; bus.y = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.x  = {$urandom(), $urandom()};
        bus.y  = {$urandom(), $urandom()};
        bus.op = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_z, input int exp_lat);
        int lat;
        issue(o, a, b);
        wait_valid(lat);
        check({name, " z"}, bus.z, exp_z);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        if (lat >= 200) begin
            bus.kill = 1'b1; @(posedge clk); #1; bus.kill = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, " in_ready after take"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic [3:0]  o;
        logic [63:0] a, b;

        rst_n = 1'b1;
        bus.in_valid = 1'b0; bus.op = '0; bus.x = '0; bus.y = '0;
        bus.kill = 1'b0; bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset in_ready",  64'(bus.in_ready),  64'd1);
        check("reset z",         bus.z,              64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back('{"mul 3*-5",       4'd0,  64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 64});
        vecs.push_back('{"mulhu ones",     4'd3,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64});
        vecs.push_back('{"mulh -1*-1",     4'd1,  '1, '1, 64'd0, 64});
        vecs.push_back('{"mulhsu -1*2",    4'd2,  '1, 64'd2, '1, 64});
        vecs.push_back('{"div -7/2",       4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64});
        vecs.push_back('{"rem -7%2",       4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 64});
        vecs.push_back('{"divu 100/7",     4'd5,  64'd100, 64'd7, 64'd14, 64});
        vecs.push_back('{"remu 100%7",     4'd7,  64'd100, 64'd7, 64'd2, 64});
        vecs.push_back('{"divw ovf",       4'd12, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 0});
        vecs.push_back('{"divu by 0",      4'd5,  64'd5, 64'd0, '1, 0});
        vecs.push_back('{"remu by 0",      4'd7,  64'd5, 64'd0, 64'd5, 0});
        vecs.push_back('{"div ovf",        4'd4,  64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0});
        vecs.push_back('{"rem ovf",        4'd6,  64'h8000_0000_0000_0000, '1, 64'd0, 0});
        vecs.push_back('{"mulw 7fffffff*2",4'd8,  64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32});
        vecs.push_back('{"op9 as mulw",    4'd9,  64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 32});
        vecs.push_back('{"remw -7%2",      4'd14, 64'h0000_0000_FFFF_FFF9, 64'd2, '1, 32});
        vecs.push_back('{"divuw hi junk",  4'd13, 64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_0000_0002, 64'h0000_0000_7FFF_FFFF, 32});
        vecs.push_back('{"divw by 0",      4'd12, 64'd5, 64'hFFFF_FFFF_0000_0000, '1, 0});
        vecs.push_back('{"remw by 0",      4'd14, 64'h0000_0001_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 0});

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].lat);

        // Backpressure: result and flags hold while the consumer stalls.
        issue(4'd0, 64'd6, 64'd7);
        wait_valid(lat);
        check("bp latency", 64'(lat), 64'd64);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp z held",         bus.z,              64'd42);
            check("bp out_valid held", 64'(bus.out_valid), 64'd1);
            check("bp in_ready low",   64'(bus.in_ready),  64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp in_ready after take",  64'(bus.in_ready),  64'd1);
        check("bp out_valid after take", 64'(bus.out_valid), 64'd0);
        run_op("after bp divu", 4'd5, 64'd100, 64'd7, 64'd14, 64);

        // Kill mid-calculation wins over a simultaneous request.
        issue(4'd0, 64'd123, 64'd456);
        repeat (10) @(posedge clk);
        #1;
        bus.kill = 1'b1; bus.in_valid = 1'b1; bus.op = 4'd5; bus.x = 64'd9; bus.y = 64'd3;
        @(posedge clk); #1;
        bus.kill = 1'b0; bus.in_valid = 1'b0;
        check("kill in_ready",  64'(bus.in_ready),  64'd1);
        check("kill out_valid", 64'(bus.out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("kill stays idle", 64'({bus.in_ready, bus.out_valid}), 64'd2);
        run_op("after kill divu 9/3", 4'd5, 64'd9, 64'd3, 64'd3, 64);

        // Asynchronous reset in the middle of a calculation.
        issue(4'd4, 64'd1000, 64'd7);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset out_valid", 64'(bus.out_valid), 64'd0);
        check("midreset z",         bus.z,              64'd0);
        check("midreset in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after reset mulw", 4'd8, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32);

        for (int i = 0; i < 120; i++) begin
            o = 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
            run_op($sformatf("rand%0d op%0d", i, o), o, a, b, ref_z(o, a, b), ref_lat(o, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
